// File: rtl/rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo
//
// Receive-side word buffer between the RX deserializer and the APB read
// interface. Words pushed by the deserializer are presented
// first-word-fall-through on reg_receive_rx and removed by a one-cycle pop
// strobe. The block also assembles the read-only RX status word and raises a
// level/overflow interrupt.
//
// Ports:
//   PCLK_rx         in   clock for the whole block
//   PRESET_rx       in   asynchronous active-high reset
//   frame_valid_rx  in   push strobe from the deserializer
//   frame_data_rx   in   word to push (sampled with frame_valid_rx)
//   read_enable_rx  in   pop strobe from the APB read side
//   clear_flags_rx  in   clears the sticky overflow/underflow flags
//   reg_receive_rx  out  head-of-FIFO word, 0 when empty
//   reg_status_rx   out  {6'b0, level, udf, empty, full, ovf, count[4:0]}
//   rx_irq          out  level (count >= THRESHOLD) OR overflow flag
// ---------------------------------------------------------------------------
module rx_frame_fifo #(
  parameter int DATAWIDTH = 16,
  parameter int DEPTH     = 16,
  parameter int PTRWIDTH  = 4,
  parameter int THRESHOLD = 8
) (
  input  logic                 PCLK_rx,
  input  logic                 PRESET_rx,
  input  logic                 frame_valid_rx,
  input  logic [DATAWIDTH-1:0] frame_data_rx,
  input  logic                 read_enable_rx,
  input  logic                 clear_flags_rx,
  output logic [DATAWIDTH-1:0] reg_receive_rx,
  output logic [15:0]          reg_status_rx,
  output logic                 rx_irq
);

  localparam logic [4:0] DEPTH_C     = 5'(DEPTH);
  localparam logic [4:0] THRESHOLD_C = 5'(THRESHOLD);

  logic [DATAWIDTH-1:0] mem [DEPTH];
  logic [PTRWIDTH-1:0]  wr_ptr;
  logic [PTRWIDTH-1:0]  rd_ptr;
  logic [4:0]           count;
  logic                 ovf_flag;
  logic                 udf_flag;

  logic empty;
  logic full;
  logic level;
  logic do_pop;
  logic do_push;
  logic ovf_event;
  logic udf_event;

  assign empty = (count == 5'd0);
  assign full  = (count == DEPTH_C);
  assign level = (count >= THRESHOLD_C);

  // A pop only happens on a non-empty FIFO. A push into a full FIFO is still
  // accepted when a pop frees the head slot in the same cycle (full implies
  // non-empty, so the pop is guaranteed to execute).
  assign do_pop    = read_enable_rx && !empty;
  assign do_push   = frame_valid_rx && (!full || do_pop);
  assign ovf_event = frame_valid_rx && full && !read_enable_rx;
  assign udf_event = read_enable_rx && empty;

  // Storage is deliberately left out of reset; only the pointers and count
  // define which entries are valid.
  always_ff @(posedge PCLK_rx) begin
    if (do_push) begin
      mem[wr_ptr] <= frame_data_rx;
    end
  end

  always_ff @(posedge PCLK_rx or posedge PRESET_rx) begin
    if (PRESET_rx) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH == 2**PTRWIDTH.
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // A new overflow/underflow in the same cycle as a clear keeps the flag set.
  always_ff @(posedge PCLK_rx or posedge PRESET_rx) begin
    if (PRESET_rx) begin
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
    end else begin
      if (ovf_event) begin
        ovf_flag <= 1'b1;
      end else if (clear_flags_rx) begin
        ovf_flag <= 1'b0;
      end
      if (udf_event) begin
        udf_flag <= 1'b1;
      end else if (clear_flags_rx) begin
        udf_flag <= 1'b0;
      end
    end
  end

  assign reg_receive_rx = empty ? '0 : mem[rd_ptr];
  assign reg_status_rx  = {6'b0, level, udf_flag, empty, full, ovf_flag, count};
  assign rx_irq         = level | ovf_flag;

endmodule
